dm_ctrl: RTL and testbench

- Data-memory access stage of the multicycle CPU, directly downstream of the byte-enable generator.
- Consumes the 4-bit byte-enable vector, the ALU address, the store data and the opcode.
- Performs byte-lane-masked stores into an internal word array, or reads and sign/zero-extends load data into the memory data register (MDR).
- Models memory wait states, so access uses a req/ready handshake and is not single-cycle.

---
 rtl/dm_ctrl_pkg.sv | 45 ++++
 rtl/dm_load_ext.sv | 37 +++
 rtl/dm_ctrl.sv | 114 +++++++++++
 tb/tb_dm_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/dm_ctrl_pkg.sv
// Shared opcode constants and request helpers for the data-memory stage.
// Imported by dm_ctrl and dm_load_ext.
package dm_ctrl_pkg;

   localparam logic [5:0] O_LB  = 6'h20;
   localparam logic [5:0] O_LH  = 6'h21;
   localparam logic [5:0] O_LW  = 6'h23;
   localparam logic [5:0] O_LBU = 6'h24;
   localparam logic [5:0] O_LHU = 6'h25;
   localparam logic [5:0] O_SB  = 6'h28;
   localparam logic [5:0] O_SH  = 6'h29;
   localparam logic [5:0] O_SW  = 6'h2b;

   typedef struct packed {
      logic [5:0]  op;
      logic [3:0]  be;
      logic [31:0] wdata;
   } dm_req_t;

   function automatic logic is_load(input logic [5:0] op);
      return op == O_LB || op == O_LH || op == O_LW ||
             op == O_LBU || op == O_LHU;
   endfunction

   function automatic logic is_store(input logic [5:0] op);
      return op == O_SB || op == O_SH || op == O_SW;
   endfunction

   function automatic logic is_word(input logic [5:0] op);
      return op == O_LW || op == O_SW;
   endfunction

   function automatic logic is_half(input logic [5:0] op);
      return op == O_LH || op == O_LHU || op == O_SH;
   endfunction

   function automatic logic is_illegal(input logic [5:0] op,
                                       input logic [3:0] be,
                                       input logic [1:0] off);
      return !(is_load(op) || is_store(op)) || be == 4'b0000 ||
             (is_word(op) && off != 2'b00) ||
             (is_half(op) && off[0]);
   endfunction

endpackage

// File: rtl/dm_load_ext.sv
// Load data extraction: selects the byte/half lane of a memory word
// and sign- or zero-extends it according to the load opcode.
module dm_load_ext
   import dm_ctrl_pkg::*;
(
   input  logic [5:0]  op_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] word_i,
   output logic [31:0] ext_o
);

   logic [7:0]  lane;
   logic [15:0] half;

   always_comb begin
      lane = word_i[7:0];
      case (off_i)
         2'd1:    lane = word_i[15:8];
         2'd2:    lane = word_i[23:16];
         2'd3:    lane = word_i[31:24];
         default: lane = word_i[7:0];
      endcase
      half = off_i[1] ? word_i[31:16] : word_i[15:0];
   end

   always_comb begin
      ext_o = word_i;
      case (op_i)
         O_LB:    ext_o = {{24{lane[7]}}, lane};
         O_LBU:   ext_o = {24'h0, lane};
         O_LH:    ext_o = {{16{half[15]}}, half};
         O_LHU:   ext_o = {16'h0, half};
         default: ext_o = word_i;
      endcase
   end

endmodule

// File: rtl/dm_ctrl.sv
// Data-memory access stage: req/ready handshake with wait states,
// byte-lane-masked stores and extended loads into the MDR.
module dm_ctrl
   import dm_ctrl_pkg::*;
#(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic [5:0]  opcode,
   input  logic [31:0] addr,
   input  logic [3:0]  be,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        ready,
   output logic        error,
   output logic [31:0] mdr
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_WAIT   = 2'd1;
   localparam logic [1:0] S_ACCESS = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   dm_req_t           req_q;
   logic [ADDR_W+1:0] addr_q;
   logic [31:0]       mdr_q;
   logic              accept;
   logic              bad, we, ld_en;
   logic [31:0]       rdata, ext;
   logic [ADDR_W-1:0] idx;

   logic [31:0] mem_q [2**ADDR_W];

   // Upper address bits alias onto the array and are dropped here.
   logic unused_addr;
   assign unused_addr = ^addr[31:ADDR_W+2];

   assign idx   = addr_q[ADDR_W+1:2];
   assign rdata = mem_q[idx];
   assign bad   = is_illegal(req_q.op, req_q.be, addr_q[1:0]);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         req_q   <= '0;
         addr_q  <= '0;
         mdr_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            req_q  <= '{op: opcode, be: be, wdata: wdata};
            addr_q <= addr[ADDR_W+1:0];
         end
         if (ld_en) mdr_q <= ext;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (req) begin
               accept  = 1'b1;
               cnt_d   = CNT_W'(WAIT_CYCLES);
               state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(1)) state_d = S_ACCESS;
         end
         S_ACCESS: state_d = S_DONE;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy  = state_q != S_IDLE;
      ready = state_q == S_DONE;
      error = (state_q == S_DONE) && bad;
      we    = (state_q == S_ACCESS) && !bad && is_store(req_q.op);
      ld_en = (state_q == S_ACCESS) && !bad && is_load(req_q.op);
   end

   // Array has no reset; an aborted request never reaches ACCESS.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we && req_q.be[i])
            mem_q[idx][8*i +: 8] <= req_q.wdata[8*i +: 8];
      end
   end

   dm_load_ext u_ext (
      .op_i   (req_q.op),
      .off_i  (addr_q[1:0]),
      .word_i (rdata),
      .ext_o  (ext)
   );

   assign mdr = mdr_q;

endmodule

// File: tb/tb_dm_ctrl.sv
// Scoreboard bench for dm_ctrl: a WAIT_CYCLES=1 instance (u1) and a
// WAIT_CYCLES=0 instance (u0) driven with directed vectors.
module tb_dm_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_s   [2];
   logic [5:0]  op_s    [2];
   logic [31:0] addr_s  [2];
   logic [3:0]  be_s    [2];
   logic [31:0] wd_s    [2];
   logic        busy_s  [2];
   logic        ready_s [2];
   logic        err_s   [2];
   logic [31:0] mdr_s   [2];

   typedef struct {
      logic [31:0] mdr;
      logic        err;
      int          acc;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dm_ctrl #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .req(req_s[0]), .opcode(op_s[0]),
      .addr(addr_s[0]), .be(be_s[0]), .wdata(wd_s[0]),
      .busy(busy_s[0]), .ready(ready_s[0]), .error(err_s[0]),
      .mdr(mdr_s[0])
   );

   dm_ctrl #(.ADDR_W(10), .WAIT_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .req(req_s[1]), .opcode(op_s[1]),
      .addr(addr_s[1]), .be(be_s[1]), .wdata(wd_s[1]),
      .busy(busy_s[1]), .ready(ready_s[1]), .error(err_s[1]),
      .mdr(mdr_s[1])
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic push(input int u, input logic [31:0] em,
                       input logic ee, input int acc);
      exp_t e;
      e.mdr = em;
      e.err = ee;
      e.acc = acc;
      if (u == 0) q0.push_back(e);
      else q1.push_back(e);
   endtask

   task automatic mon(input int u);
      exp_t e;
      logic have;
      have = (u == 0) ? (q0.size() > 0) : (q1.size() > 0);
      if (!have) begin
         chk($sformatf("u%0d spurious ready", u), 32'(ready_s[u]), 32'h0);
      end else begin
         e = (u == 0) ? q0.pop_front() : q1.pop_front();
         chk($sformatf("u%0d mdr", u), mdr_s[u], e.mdr);
         chk($sformatf("u%0d error", u), 32'(err_s[u]), 32'(e.err));
         chk($sformatf("u%0d latency", u), 32'(cyc - e.acc), 32'(u + 2));
         chk($sformatf("u%0d busy@ready", u), 32'(busy_s[u]), 32'h1);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && ready_s[0]) mon(0);
      if (!rst && ready_s[1]) mon(1);
   end

   task automatic drive(input int u, input logic [5:0] op,
                        input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d);
      req_s[u]  = 1'b1;
      op_s[u]   = op;
      addr_s[u] = a;
      be_s[u]   = b;
      wd_s[u]   = d;
   endtask

   task automatic scramble(input int u);
      req_s[u]  = 1'b0;
      op_s[u]   = 6'h3f;
      addr_s[u] = 32'hFFFF_FFFF;
      be_s[u]   = 4'h0;
      wd_s[u]   = 32'hA5A5_A5A5;
   endtask

   task automatic wait_idle(input int u);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!busy_s[u]) break;
      end
      chk($sformatf("u%0d idle timeout", u), 32'(busy_s[u]), 32'h0);
   endtask

   task automatic issue(input int u, input logic [5:0] op,
                        input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d, input logic [31:0] em,
                        input logic ee);
      @(negedge clk);
      drive(u, op, a, b, d);
      @(posedge clk);
      #1;
      push(u, em, ee, cyc - 1);
      scramble(u);
      wait_idle(u);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      scramble(0);
      scramble(1);
      repeat (3) @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         chk($sformatf("u%0d rst busy", u), 32'(busy_s[u]), 32'h0);
         chk($sformatf("u%0d rst ready", u), 32'(ready_s[u]), 32'h0);
         chk($sformatf("u%0d rst error", u), 32'(err_s[u]), 32'h0);
         chk($sformatf("u%0d rst mdr", u), mdr_s[u], 32'h0);
      end
      rst = 1'b0;

      issue(1, 6'h2b, 32'h10, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0);
      issue(1, 6'h23, 32'h10, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0);

      issue(1, 6'h2b, 32'h20, 4'hF, 32'h80FF_7F01, 32'hDEAD_BEEF, 1'b0);
      issue(1, 6'h20, 32'h23, 4'hF, 32'h0, 32'hFFFF_FF80, 1'b0);
      issue(1, 6'h24, 32'h23, 4'hF, 32'h0, 32'h0000_0080, 1'b0);
      issue(1, 6'h20, 32'h20, 4'hF, 32'h0, 32'h0000_0001, 1'b0);

      issue(1, 6'h29, 32'h12, 4'hC, 32'h1234_0000, 32'h0000_0001, 1'b0);
      issue(1, 6'h23, 32'h10, 4'hF, 32'h0, 32'h1234_BEEF, 1'b0);
      issue(1, 6'h21, 32'h12, 4'hF, 32'h0, 32'h0000_1234, 1'b0);
      issue(1, 6'h25, 32'h10, 4'hF, 32'h0, 32'h0000_BEEF, 1'b0);
      issue(1, 6'h21, 32'h10, 4'hF, 32'h0, 32'hFFFF_BEEF, 1'b0);

      issue(1, 6'h23, 32'h11, 4'hF, 32'h0, 32'hFFFF_BEEF, 1'b1);
      issue(1, 6'h21, 32'h13, 4'hF, 32'h0, 32'hFFFF_BEEF, 1'b1);
      issue(1, 6'h00, 32'h10, 4'hF, 32'h0, 32'hFFFF_BEEF, 1'b1);
      issue(1, 6'h2b, 32'h11, 4'hF, 32'hFFFF_FFFF, 32'hFFFF_BEEF, 1'b1);
      issue(1, 6'h28, 32'h10, 4'h0, 32'hFFFF_FFFF, 32'hFFFF_BEEF, 1'b1);
      issue(1, 6'h23, 32'h10, 4'hF, 32'h0, 32'h1234_BEEF, 1'b0);
      issue(1, 6'h23, 32'h8000_1010, 4'hF, 32'h0, 32'h1234_BEEF, 1'b0);

      issue(1, 6'h2b, 32'h30, 4'hF, 32'h1122_3344, 32'h1234_BEEF, 1'b0);
      @(negedge clk);
      drive(1, 6'h2b, 32'h30, 4'hF, 32'h5555_5555);
      @(posedge clk);
      #1;
      scramble(1);
      rst = 1'b1;
      #1;
      chk("abort busy", 32'(busy_s[1]), 32'h0);
      chk("abort ready", 32'(ready_s[1]), 32'h0);
      chk("abort error", 32'(err_s[1]), 32'h0);
      chk("abort mdr", mdr_s[1], 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      issue(1, 6'h23, 32'h30, 4'hF, 32'h0, 32'h1122_3344, 1'b0);

      @(negedge clk);
      drive(1, 6'h24, 32'h20, 4'hF, 32'h0);
      @(posedge clk);
      #1;
      push(1, 32'h0000_0001, 1'b0, cyc - 1);
      repeat (4) @(posedge clk);
      #1;
      push(1, 32'h0000_0001, 1'b0, cyc - 1);
      scramble(1);
      wait_idle(1);

      issue(0, 6'h2b, 32'h40, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b0);
      @(negedge clk);
      drive(0, 6'h23, 32'h40, 4'hF, 32'h0);
      @(posedge clk);
      #1;
      push(0, 32'hCAFE_F00D, 1'b0, cyc - 1);
      scramble(0);
      @(negedge clk);
      drive(0, 6'h2b, 32'h40, 4'hF, 32'h0BAD_0BAD);
      @(negedge clk);
      scramble(0);
      wait_idle(0);
      issue(0, 6'h24, 32'h41, 4'hF, 32'h0, 32'h0000_00F0, 1'b0);
      issue(0, 6'h21, 32'h42, 4'hF, 32'h0, 32'hFFFF_CAFE, 1'b0);

      repeat (6) @(negedge clk);
      chk("u0 queue drained", 32'(q0.size()), 32'h0);
      chk("u1 queue drained", 32'(q1.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
